// File: rtl/ex_div_unit_pkg.sv
// Shared types and constants for the execute-stage iterative divider.
package ex_div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned CNT_WIDTH = 5;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DIV_WIDTH - 1);

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] rem;
        logic [DIV_WIDTH-1:0] quo;
    } div_result_t;

    // Magnitude of a two's-complement value when signed operation is selected.
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v,
                                                     input logic                 is_signed);
        return (is_signed && v[DIV_WIDTH-1]) ? DIV_WIDTH'(-v) : v;
    endfunction

endpackage

// File: rtl/ex_div_unit_step.sv
// One restoring-division step on the {rem, quo} working register.
import ex_div_unit_pkg::*;

module ex_div_unit_step (
    input  logic [2*DIV_WIDTH-1:0] work,
    input  logic [DIV_WIDTH-1:0]   divisor,
    output logic [2*DIV_WIDTH-1:0] work_next
);

    logic [2*DIV_WIDTH-1:0] shifted;
    logic [DIV_WIDTH:0]     partial;
    logic [DIV_WIDTH:0]     trial;
    logic                   fits;

    // The bit shifted out of rem is kept as a 33rd partial-remainder bit so
    // divisors with the MSB set are handled correctly.
    always_comb begin
        shifted   = {work[2*DIV_WIDTH-2:0], 1'b0};
        partial   = {work[2*DIV_WIDTH-1], shifted[2*DIV_WIDTH-1:DIV_WIDTH]};
        fits      = partial >= {1'b0, divisor};
        trial     = (DIV_WIDTH+1)'(partial - {1'b0, divisor});
        work_next = {shifted[2*DIV_WIDTH-1:1], 1'b0};
        if (fits) begin
            work_next = {trial[DIV_WIDTH-1:0], shifted[DIV_WIDTH-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative signed/unsigned 32-bit divider with stall, annul and divide-by-zero handling.
import ex_div_unit_pkg::*;

module ex_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     dividend_i,
    input  logic [WIDTH-1:0]     divisor_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stall_o
);

    div_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [2*DIV_WIDTH-1:0] work_q, work_d;
    logic [DIV_WIDTH-1:0]   dvsr_q, dvsr_d;
    logic                   neg_q_q, neg_q_d;
    logic                   neg_r_q, neg_r_d;
    div_result_t            result_q, result_d;
    logic                   ready_q, ready_d;
    logic [2*DIV_WIDTH-1:0] step_work;

    ex_div_unit_step u_step (
        .work      (work_q),
        .divisor   (dvsr_q),
        .work_next (step_work)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            work_q   <= '0;
            dvsr_q   <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvsr_q   <= dvsr_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state, datapath update, sign fix-up and stall request.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvsr_d   = dvsr_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;
        ready_d  = ready_q;
        stall_o  = 1'b0;

        case (state_q)
            DIV_FREE: begin
                if (start_i && !annul_i) begin
                    stall_o = 1'b1;
                    work_d  = {{DIV_WIDTH{1'b0}}, abs_val(DIV_WIDTH'(dividend_i), signed_i)};
                    dvsr_d  = abs_val(DIV_WIDTH'(divisor_i), signed_i);
                    neg_q_d = signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                    neg_r_d = signed_i && dividend_i[WIDTH-1];
                    cnt_d   = '0;
                    state_d = (divisor_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                stall_o  = 1'b1;
                work_d   = '0;
                result_d = '0;
                ready_d  = DIV_RESULT_READY;
                state_d  = DIV_END;
            end
            DIV_ON: begin
                stall_o = 1'b1;
                work_d  = step_work;
                cnt_d   = CNT_WIDTH'(cnt_q + CNT_WIDTH'(1));
                if (cnt_q == CNT_LAST) begin
                    result_d.quo = neg_q_q ? DIV_WIDTH'(-step_work[DIV_WIDTH-1:0])
                                           : step_work[DIV_WIDTH-1:0];
                    result_d.rem = neg_r_q ? DIV_WIDTH'(-step_work[2*DIV_WIDTH-1:DIV_WIDTH])
                                           : step_work[2*DIV_WIDTH-1:DIV_WIDTH];
                    ready_d      = DIV_RESULT_READY;
                    state_d      = DIV_END;
                end
            end
            DIV_END: begin
                if (!start_i) begin
                    ready_d = DIV_RESULT_NOT_READY;
                    state_d = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase

        // Flush abandons the operation without touching the last result.
        if (annul_i) begin
            state_d  = DIV_FREE;
            ready_d  = DIV_RESULT_NOT_READY;
            result_d = result_q;
        end
    end

    assign result_o = (2*WIDTH)'(result_q);
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed, table-driven self-checking bench for ex_div_unit.
module tb_ex_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    int tests;
    int fails;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    ex_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stall_o    (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide, check latency/stall/result, optionally hold start past ready.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic [31:0] q, input logic [31:0] r, input int lat,
                           input int hold);
        int cyc;
        int stall_bad;
        int hold_bad;
        start_i    = 1'b1;
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        #1;
        check("stall_accept", 64'(stall_o), 64'd1);
        cyc       = 0;
        stall_bad = 0;
        do begin
            tick();
            dividend_i = $urandom;
            divisor_i  = $urandom;
            cyc++;
            if (!ready_o && !stall_o) stall_bad++;
        end while (!ready_o && cyc < 100);
        check("ready_seen", 64'(ready_o), 64'd1);
        check("latency", 64'(cyc), 64'(lat));
        check("stall_busy", 64'(stall_bad), 64'd0);
        check("stall_at_ready", 64'(stall_o), 64'd0);
        check("result", result_o, {r, q});
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!ready_o || stall_o || result_o !== {r, q}) hold_bad++;
        end
        if (hold > 0) check("hold_done", 64'(hold_bad), 64'd0);
        start_i = 1'b0;
        tick();
        check("ready_drop", 64'(ready_o), 64'd0);
        check("result_kept", result_o, {r, q});
    endtask

    initial begin
        int cyc;
        int rose;
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        annul_i    = 1'b0;

        vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         33};
        vecs[1]  = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  33};
        vecs[2]  = '{32'hFFFFFFF9,  32'd2,         1'b0, 32'h7FFFFFFC,  32'd1,         33};
        vecs[3]  = '{32'd5,         32'd0,         1'b0, 32'd0,         32'd0,         2};
        vecs[4]  = '{32'hFFFFFFFB,  32'd0,         1'b1, 32'd0,         32'd0,         2};
        vecs[5]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         33};
        vecs[6]  = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,         32'h80000000,  33};
        vecs[7]  = '{32'hFFFFFFFF,  32'h80000000,  1'b0, 32'd1,         32'h7FFFFFFF,  33};
        vecs[8]  = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         33};
        vecs[9]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, 32'd3,         32'hFFFFFFFF,  33};
        vecs[10] = '{32'h12345678,  32'h00000100,  1'b0, 32'h00123456,  32'h00000078,  33};

        // Reset values.
        tick();
        tick();
        check("rst_result", result_o, 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        rst = 1'b0;
        tick();

        // Annul has priority over start in IDLE.
        start_i   = 1'b1;
        annul_i   = 1'b1;
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        #1;
        check("annul_idle_stall", 64'(stall_o), 64'd0);
        tick();
        check("annul_idle_stay", 64'(stall_o | ready_o), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].q, vecs[i].r, vecs[i].lat, 0);
        end

        // Annul at the 10th BUSY cycle: no ready, previous result retained.
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        for (int i = 0; i < 10; i++) tick();
        check("busy_stall", 64'(stall_o), 64'd1);
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        check("annul_stall", 64'(stall_o), 64'd0);
        rose = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (ready_o) rose++;
            tick();
        end
        check("annul_no_ready", 64'(rose), 64'd0);
        check("annul_result", result_o, {32'd0, 32'h00123456} | {32'h00000078, 32'd0});
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, 0);

        // Hold start five cycles past ready.
        run_div(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 33, 5);
        check("idle_stall", 64'(stall_o), 64'd0);

        // Reset in the 20th BUSY cycle clears every output.
        start_i    = 1'b1;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        for (int i = 0; i < 20; i++) tick();
        rst     = 1'b1;
        start_i = 1'b0;
        tick();
        check("midrst_result", result_o, 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_stall", 64'(stall_o), 64'd0);
        rst = 1'b0;
        tick();
        run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
